// File: rtl/pipe_dbg_defs_pkg.sv
// Shared encodings for the pipeline run monitor: FSM states, fail codes, halt encoding.
package pipe_dbg_defs_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } run_state_e;

   localparam logic [1:0] FAIL_NONE     = 2'd0;
   localparam logic [1:0] FAIL_TIMEOUT  = 2'd1;
   localparam logic [1:0] FAIL_DEADLOCK = 2'd2;

   // ecall
   localparam logic [31:0] HALT_INSN_DEFAULT = 32'h0000_0073;

endpackage

// File: rtl/shadow_regfile.sv
// Shadow copy of the architectural register file, built from retired writebacks.
module shadow_regfile #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned RA_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            we,
   input  logic [RA_W-1:0] waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [RA_W-1:0] raddr,
   output logic [XLEN-1:0] rdata
);

   localparam int unsigned NumRegs = 2 ** RA_W;

   logic [XLEN-1:0] regs_q [NumRegs];
   logic [XLEN-1:0] regs_d [NumRegs];

   // Next-state: single write port, x0 is hardwired to zero so its writes are dropped.
   always_comb begin
      regs_d = regs_q;
      if (we && (waddr != '0)) begin
         regs_d[waddr] = wdata;
      end
   end

   // Register storage with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NumRegs; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Combinational read port; x0 always reads zero.
   always_comb begin
      rdata = '0;
      if (raddr != '0) begin
         rdata = regs_q[raddr];
      end
   end

endmodule

// File: rtl/pipeline_run_monitor.sv
// Run controller/monitor: watches the retire stream, counts cycles and retires,
// detects halt, deadlock and timeout, and reports done/pass/fail.
module pipeline_run_monitor
   import pipe_dbg_defs_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter int unsigned     RA_W         = 5,
   parameter int unsigned     MAX_CYCLES   = 15,
   parameter int unsigned     STALL_LIMIT  = 8,
   parameter int unsigned     DRAIN_CYCLES = 4,
   parameter logic [XLEN-1:0] HALT_INSN    = XLEN'(HALT_INSN_DEFAULT),
   parameter int unsigned     CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             wb_valid,
   input  logic [XLEN-1:0]  wb_insn,
   input  logic             wb_we,
   input  logic [RA_W-1:0]  wb_rd,
   input  logic [XLEN-1:0]  wb_wdata,
   input  logic [RA_W-1:0]  dbg_addr,
   output logic [XLEN-1:0]  dbg_data,
   output logic             running,
   output logic             done,
   output logic             pass,
   output logic [1:0]       fail_code,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt
);

   localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);
   localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);

   run_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cycle_q, cycle_d;
   logic [CNT_W-1:0]  retire_q, retire_d;
   logic [StallW-1:0] stall_q, stall_d;
   logic [DrainW-1:0] drain_q, drain_d;
   logic              pass_q, pass_d;
   logic [1:0]        fail_q, fail_d;

   logic active;
   logic halt;

   assign active = (state_q == StRun) || (state_q == StDrain);
   assign halt   = wb_valid && (wb_insn == HALT_INSN);

   // Next-state and counter update; halt beats timeout beats deadlock in the same cycle.
   always_comb begin
      state_d  = state_q;
      cycle_d  = cycle_q;
      retire_d = retire_q;
      stall_d  = stall_q;
      drain_d  = drain_q;
      pass_d   = pass_q;
      fail_d   = fail_q;

      if (active) begin
         cycle_d = (&cycle_q) ? cycle_q : cycle_q + 1'b1;
         if (wb_valid) begin
            retire_d = (&retire_q) ? retire_q : retire_q + 1'b1;
         end
      end

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d  = StRun;
               cycle_d  = '0;
               retire_d = '0;
               stall_d  = '0;
               drain_d  = '0;
               pass_d   = 1'b0;
               fail_d   = FAIL_NONE;
            end
         end
         StRun: begin
            stall_d = wb_valid ? '0 : stall_q + 1'b1;
            if (halt) begin
               state_d = StDrain;
               drain_d = '0;
            end else if (cycle_q >= CNT_W'(MAX_CYCLES - 1)) begin
               state_d = StDone;
               fail_d  = FAIL_TIMEOUT;
            end else if (!wb_valid && (stall_q == StallW'(STALL_LIMIT - 1))) begin
               // This is the STALL_LIMIT-th consecutive cycle without a retire.
               state_d = StDone;
               fail_d  = FAIL_DEADLOCK;
            end
         end
         StDrain: begin
            if (drain_q == DrainW'(DRAIN_CYCLES - 1)) begin
               state_d = StDone;
               pass_d  = 1'b1;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and counter registers; reset aborts any run immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         cycle_q  <= '0;
         retire_q <= '0;
         stall_q  <= '0;
         drain_q  <= '0;
         pass_q   <= 1'b0;
         fail_q   <= FAIL_NONE;
      end else begin
         state_q  <= state_d;
         cycle_q  <= cycle_d;
         retire_q <= retire_d;
         stall_q  <= stall_d;
         drain_q  <= drain_d;
         pass_q   <= pass_d;
         fail_q   <= fail_d;
      end
   end

   // Writebacks land in the shadow file only while a run is live (RUN or DRAIN).
   shadow_regfile #(
      .XLEN (XLEN),
      .RA_W (RA_W)
   ) u_shadow_regfile (
      .clk   (clk),
      .reset (reset),
      .we    (active && wb_valid && wb_we),
      .waddr (wb_rd),
      .wdata (wb_wdata),
      .raddr (dbg_addr),
      .rdata (dbg_data)
   );

   // Status outputs come straight from registered state.
   always_comb begin
      running    = active;
      done       = (state_q == StDone);
      pass       = pass_q;
      fail_code  = fail_q;
      cycle_cnt  = cycle_q;
      retire_cnt = retire_q;
   end

endmodule
